// File: rtl/rs_station_pkg.sv
// rs_station_pkg: shared defaults, opcode classes and per-entry control payload for the reservation station
package rs_station_pkg;
    localparam int RS_DEPTH_DEF  = 8;
    localparam int ROB_BITS_DEF  = 4;
    localparam int CDB_PORTS_DEF = 2;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [6:0]  op_type;
        logic [2:0]  funct3;
        logic        funct7b;
        logic [31:0] pc;
    } rs_ctrl_t;
endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: picks the ready entry whose tag is closest to rob_head, ties to the lowest index
module rs_age_select
    import rs_station_pkg::*;
#(
    parameter int DEPTH    = RS_DEPTH_DEF,
    parameter int ROB_BITS = ROB_BITS_DEF
) (
    input  logic [DEPTH-1:0]          ready_mask,
    input  logic [DEPTH*ROB_BITS-1:0] tags,
    input  logic [ROB_BITS-1:0]       rob_head,
    output logic [$clog2(DEPTH)-1:0]  idx,
    output logic                      found
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [ROB_BITS-1:0] age, best_age;

    // modular distance from the head is the age; strict < keeps the lowest index on ties
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        age      = '0;
        best_age = '1;
        for (int i = 0; i < DEPTH; i++) begin
            age = tags[i*ROB_BITS +: ROB_BITS] - rob_head;
            if (ready_mask[i] && (!found || age < best_age)) begin
                found    = 1'b1;
                idx      = IDX_W'(i);
                best_age = age;
            end
        end
    end
endmodule

// File: rtl/rs_station.sv
// rs_station: reservation station with CDB wakeup, issue bypass and oldest-first registered dispatch
module rs_station
    import rs_station_pkg::*;
#(
    parameter int RS_DEPTH  = RS_DEPTH_DEF,
    parameter int ROB_BITS  = ROB_BITS_DEF,
    parameter int CDB_PORTS = CDB_PORTS_DEF
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush_in,
    input  logic [ROB_BITS-1:0]           rob_head,
    input  logic                          issue_valid,
    input  logic [6:0]                    issue_op_type,
    input  logic [2:0]                    issue_funct3,
    input  logic                          issue_funct7b,
    input  logic [31:0]                   issue_vj,
    input  logic [31:0]                   issue_vk,
    input  logic                          issue_qj_busy,
    input  logic                          issue_qk_busy,
    input  logic [ROB_BITS-1:0]           issue_qj,
    input  logic [ROB_BITS-1:0]           issue_qk,
    input  logic [ROB_BITS-1:0]           issue_rob,
    input  logic [31:0]                   issue_pc,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*ROB_BITS-1:0] cdb_rob,
    input  logic [CDB_PORTS*32-1:0]       cdb_value,
    output logic                          alu_valid,
    input  logic                          alu_ready,
    output logic [31:0]                   alu_vj,
    output logic [31:0]                   alu_vk,
    output logic [31:0]                   alu_pc,
    output logic [6:0]                    alu_op_type,
    output logic [2:0]                    alu_funct3,
    output logic                          alu_funct7b,
    output logic [ROB_BITS-1:0]           alu_rob,
    output logic                          full,
    output logic [$clog2(RS_DEPTH):0]     count
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_DEPTH-1:0] busy_q, busy_d, qj_busy_q, qj_busy_d, qk_busy_q, qk_busy_d;
    logic [ROB_BITS-1:0] qj_q [RS_DEPTH], qj_d [RS_DEPTH];
    logic [ROB_BITS-1:0] qk_q [RS_DEPTH], qk_d [RS_DEPTH];
    logic [ROB_BITS-1:0] rob_q [RS_DEPTH], rob_d [RS_DEPTH];
    logic [31:0]         vj_q [RS_DEPTH], vj_d [RS_DEPTH];
    logic [31:0]         vk_q [RS_DEPTH], vk_d [RS_DEPTH];
    rs_ctrl_t            ctrl_q [RS_DEPTH], ctrl_d [RS_DEPTH];

    logic                alu_valid_q, alu_valid_d;
    logic [31:0]         alu_vj_q, alu_vj_d, alu_vk_q, alu_vk_d;
    logic [ROB_BITS-1:0] alu_rob_q, alu_rob_d;
    rs_ctrl_t            alu_ctrl_q, alu_ctrl_d;

    logic [RS_DEPTH*ROB_BITS-1:0] tags_flat;
    logic [RS_DEPTH-1:0]          ready_mask;
    logic [IDX_W-1:0]             sel_idx, free_idx;
    logic [CNT_W-1:0]             count_c;
    logic                         sel_found, load, issue_acc;
    logic [32:0]                  hj, hk, ij, ik;

    // {hit, value}; scanning high to low lets the lowest matching port win
    function automatic logic [32:0] cdb_hit(input logic [ROB_BITS-1:0] tag);
        cdb_hit = '0;
        for (int p = CDB_PORTS - 1; p >= 0; p--)
            if (cdb_valid[p] && cdb_rob[p*ROB_BITS +: ROB_BITS] == tag)
                cdb_hit = {1'b1, cdb_value[p*32 +: 32]};
    endfunction

    always_comb begin
        count_c   = '0;
        tags_flat = '0;
        free_idx  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            count_c = count_c + CNT_W'(busy_q[i]);
            tags_flat[i*ROB_BITS +: ROB_BITS] = rob_q[i];
        end
        for (int i = RS_DEPTH - 1; i >= 0; i--)
            if (!busy_q[i]) free_idx = IDX_W'(i);
    end

    assign ready_mask = busy_q & ~qj_busy_q & ~qk_busy_q;
    assign full       = &busy_q;
    assign count      = count_c;
    assign issue_acc  = issue_valid && !full;
    assign load       = sel_found && (!alu_valid_q || alu_ready);

    rs_age_select #(.DEPTH(RS_DEPTH), .ROB_BITS(ROB_BITS)) u_sel (
        .ready_mask(ready_mask),
        .tags      (tags_flat),
        .rob_head  (rob_head),
        .idx       (sel_idx),
        .found     (sel_found)
    );

    always_comb begin
        busy_d      = busy_q;
        qj_busy_d   = qj_busy_q;
        qk_busy_d   = qk_busy_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        rob_d       = rob_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        ctrl_d      = ctrl_q;
        alu_valid_d = alu_valid_q;
        alu_vj_d    = alu_vj_q;
        alu_vk_d    = alu_vk_q;
        alu_rob_d   = alu_rob_q;
        alu_ctrl_d  = alu_ctrl_q;
        hj          = '0;
        hk          = '0;
        ij          = cdb_hit(issue_qj);
        ik          = cdb_hit(issue_qk);
        if (rdy_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                hj = cdb_hit(qj_q[i]);
                hk = cdb_hit(qk_q[i]);
                if (busy_q[i] && qj_busy_q[i] && hj[32]) begin
                    qj_busy_d[i] = 1'b0;
                    vj_d[i]      = hj[31:0];
                end
                if (busy_q[i] && qk_busy_q[i] && hk[32]) begin
                    qk_busy_d[i] = 1'b0;
                    vk_d[i]      = hk[31:0];
                end
            end
            if (load) begin
                busy_d[sel_idx] = 1'b0;
                alu_valid_d     = 1'b1;
                alu_vj_d        = vj_q[sel_idx];
                alu_vk_d        = vk_q[sel_idx];
                alu_rob_d       = rob_q[sel_idx];
                alu_ctrl_d      = ctrl_q[sel_idx];
            end else if (alu_ready) begin
                alu_valid_d = 1'b0;
            end
            if (issue_acc) begin
                busy_d[free_idx]    = 1'b1;
                qj_busy_d[free_idx] = issue_qj_busy && !ij[32];
                qk_busy_d[free_idx] = issue_qk_busy && !ik[32];
                vj_d[free_idx]      = (issue_qj_busy && ij[32]) ? ij[31:0] : issue_vj;
                vk_d[free_idx]      = (issue_qk_busy && ik[32]) ? ik[31:0] : issue_vk;
                qj_d[free_idx]      = issue_qj;
                qk_d[free_idx]      = issue_qk;
                rob_d[free_idx]     = issue_rob;
                ctrl_d[free_idx]    = '{issue_op_type, issue_funct3, issue_funct7b, issue_pc};
            end
            if (flush_in) begin
                busy_d      = '0;
                alu_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q      <= '0;
            qj_busy_q   <= '0;
            qk_busy_q   <= '0;
            alu_valid_q <= 1'b0;
            alu_vj_q    <= '0;
            alu_vk_q    <= '0;
            alu_rob_q   <= '0;
            alu_ctrl_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            qj_busy_q   <= qj_busy_d;
            qk_busy_q   <= qk_busy_d;
            alu_valid_q <= alu_valid_d;
            alu_vj_q    <= alu_vj_d;
            alu_vk_q    <= alu_vk_d;
            alu_rob_q   <= alu_rob_d;
            alu_ctrl_q  <= alu_ctrl_d;
        end
    end

    // entry payload is only meaningful while busy, so it carries no reset
    always_ff @(posedge clk_in) begin
        qj_q   <= qj_d;
        qk_q   <= qk_d;
        rob_q  <= rob_d;
        vj_q   <= vj_d;
        vk_q   <= vk_d;
        ctrl_q <= ctrl_d;
    end

    assign alu_valid   = alu_valid_q;
    assign alu_vj      = alu_vj_q;
    assign alu_vk      = alu_vk_q;
    assign alu_rob     = alu_rob_q;
    assign alu_pc      = alu_ctrl_q.pc;
    assign alu_op_type = alu_ctrl_q.op_type;
    assign alu_funct3  = alu_ctrl_q.funct3;
    assign alu_funct7b = alu_ctrl_q.funct7b;
endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station: directed vectors and sequences plus randomized run against a behavioural model
module tb_rs_station;
    import rs_station_pkg::*;

    localparam int D = 8, RB = 4, CP = 2;

    logic              clk_in = 1'b0;
    logic              rst_in, rdy_in, flush_in;
    logic [RB-1:0]     rob_head;
    logic              issue_valid;
    logic [6:0]        issue_op_type;
    logic [2:0]        issue_funct3;
    logic              issue_funct7b;
    logic [31:0]       issue_vj, issue_vk, issue_pc;
    logic              issue_qj_busy, issue_qk_busy;
    logic [RB-1:0]     issue_qj, issue_qk, issue_rob;
    logic [CP-1:0]     cdb_valid;
    logic [CP*RB-1:0]  cdb_rob;
    logic [CP*32-1:0]  cdb_value;
    logic              alu_valid, alu_ready;
    logic [31:0]       alu_vj, alu_vk, alu_pc;
    logic [6:0]        alu_op_type;
    logic [2:0]        alu_funct3;
    logic              alu_funct7b;
    logic [RB-1:0]     alu_rob;
    logic              full;
    logic [$clog2(D):0] count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    rs_station #(.RS_DEPTH(D), .ROB_BITS(RB), .CDB_PORTS(CP)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in), .rob_head(rob_head),
        .issue_valid(issue_valid), .issue_op_type(issue_op_type), .issue_funct3(issue_funct3),
        .issue_funct7b(issue_funct7b), .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy), .issue_qj(issue_qj),
        .issue_qk(issue_qk), .issue_rob(issue_rob), .issue_pc(issue_pc),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_vj(alu_vj), .alu_vk(alu_vk),
        .alu_pc(alu_pc), .alu_op_type(alu_op_type), .alu_funct3(alu_funct3),
        .alu_funct7b(alu_funct7b), .alu_rob(alu_rob), .full(full), .count(count)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        issue_valid = 1'b0; cdb_valid = '0; alu_ready = 1'b1;
    endtask

    task automatic put(input logic [3:0] rob, input logic [31:0] vj, input logic [31:0] vk,
                       input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk);
        issue_valid = 1'b1; issue_rob = rob; issue_vj = vj; issue_vk = vk;
        issue_qj_busy = qjb; issue_qj = qj; issue_qk_busy = qkb; issue_qk = qk;
        issue_pc = 32'h100 + 32'(rob) * 4; issue_op_type = OP_ALU;
        issue_funct3 = rob[2:0]; issue_funct7b = rob[0];
    endtask

    task automatic cdb(input int p, input logic [3:0] tag, input logic [31:0] val);
        cdb_valid[p] = 1'b1;
        cdb_rob[p*RB +: RB] = tag;
        cdb_value[p*32 +: 32] = val;
    endtask

    // behavioural model: a set of slots, oldest-by-distance-from-head leaves first
    logic          m_busy [D];
    logic          m_wj [D], m_wk [D];
    logic [3:0]    m_tj [D], m_tk [D], m_rob [D];
    logic [31:0]   m_vj [D], m_vk [D], m_pc [D];
    logic [10:0]   m_ctl [D];
    logic          m_ov;
    logic [31:0]   o_vj, o_vk, o_pc;
    logic [3:0]    o_rob;
    logic [10:0]   o_ctl;

    function automatic logic [32:0] bcast(input logic [3:0] tag);
        for (int p = 0; p < CP; p++)
            if (cdb_valid[p] && cdb_rob[p*RB +: RB] == tag) return {1'b1, cdb_value[p*32 +: 32]};
        return '0;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < D; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    task automatic model_cycle();
        int fr, sel, best, age;
        logic [32:0] b;
        if (rst_in) begin
            for (int i = 0; i < D; i++) m_busy[i] = 1'b0;
            m_ov = 1'b0; o_vj = 0; o_vk = 0; o_pc = 0; o_rob = 0; o_ctl = 0;
            return;
        end
        if (!rdy_in) return;
        if (flush_in) begin
            for (int i = 0; i < D; i++) m_busy[i] = 1'b0;
            m_ov = 1'b0;
            return;
        end
        fr = -1; sel = -1; best = 1000;
        for (int i = 0; i < D; i++) begin
            if (!m_busy[i] && fr < 0) fr = i;
            if (m_busy[i] && !m_wj[i] && !m_wk[i]) begin
                age = (int'(m_rob[i]) - int'(rob_head) + 16) % 16;
                if (age < best) begin best = age; sel = i; end
            end
        end
        if (!m_ov || alu_ready) begin
            m_ov = (sel >= 0);
            if (sel >= 0) begin
                o_vj = m_vj[sel]; o_vk = m_vk[sel]; o_pc = m_pc[sel]; o_rob = m_rob[sel]; o_ctl = m_ctl[sel];
                m_busy[sel] = 1'b0;
            end
        end
        for (int i = 0; i < D; i++) begin
            if (m_busy[i] && m_wj[i]) begin
                b = bcast(m_tj[i]);
                if (b[32]) begin m_wj[i] = 1'b0; m_vj[i] = b[31:0]; end
            end
            if (m_busy[i] && m_wk[i]) begin
                b = bcast(m_tk[i]);
                if (b[32]) begin m_wk[i] = 1'b0; m_vk[i] = b[31:0]; end
            end
        end
        if (issue_valid && fr >= 0) begin
            m_busy[fr] = 1'b1; m_rob[fr] = issue_rob; m_pc[fr] = issue_pc;
            m_ctl[fr] = {issue_op_type, issue_funct3, issue_funct7b};
            m_tj[fr] = issue_qj; m_tk[fr] = issue_qk;
            b = bcast(issue_qj);
            m_wj[fr] = issue_qj_busy && !b[32];
            m_vj[fr] = (issue_qj_busy && b[32]) ? b[31:0] : issue_vj;
            b = bcast(issue_qk);
            m_wk[fr] = issue_qk_busy && !b[32];
            m_vk[fr] = (issue_qk_busy && b[32]) ? b[31:0] : issue_vk;
        end
    endtask

    typedef struct {
        logic [3:0]  rob;
        logic [31:0] vj, vk;
        logic        qkb;
        logic [3:0]  qk;
        logic        cen;
        int          cport;
        logic [3:0]  ctag;
        logic [31:0] cval;
        logic [31:0] exp_vk;
    } vec_t;

    vec_t tab [4];

    initial begin
        idle();
        rob_head = '0; issue_op_type = '0; issue_funct3 = '0; issue_funct7b = 1'b0;
        issue_vj = '0; issue_vk = '0; issue_pc = '0; issue_qj_busy = 1'b0; issue_qk_busy = 1'b0;
        issue_qj = '0; issue_qk = '0; issue_rob = '0; cdb_rob = '0; cdb_value = '0;
        rst_in = 1'b1;
        step(); step();
        idle();
        chk("reset_valid", alu_valid, 0);
        chk("reset_full", full, 0);
        chk("reset_count", count, 0);
        chk("reset_data", {alu_vj, alu_vk, alu_pc, alu_rob}, 0);

        tab[0] = '{4'd3,  32'd5,        32'd7, 1'b0, 4'd0,  1'b0, 0, 4'd0,  32'h0,    32'd7};
        tab[1] = '{4'd6,  32'h11,       32'd0, 1'b1, 4'd4,  1'b1, 0, 4'd4,  32'hAA,   32'hAA};
        tab[2] = '{4'd9,  32'hDEADBEEF, 32'd1, 1'b0, 4'd9,  1'b1, 1, 4'd9,  32'h55,   32'd1};
        tab[3] = '{4'd12, 32'h2,        32'd0, 1'b1, 4'd13, 1'b1, 1, 4'd13, 32'hCAFE, 32'hCAFE};
        for (int t = 0; t < 4; t++) begin
            put(tab[t].rob, tab[t].vj, tab[t].vk, 1'b0, 4'd0, tab[t].qkb, tab[t].qk);
            if (tab[t].cen) cdb(tab[t].cport, tab[t].ctag, tab[t].cval);
            step();
            idle();
            chk($sformatf("vec%0d_count", t), count, 1);
            chk($sformatf("vec%0d_early", t), alu_valid, 0);
            step();
            chk($sformatf("vec%0d_valid", t), alu_valid, 1);
            chk($sformatf("vec%0d_ops", t), {alu_vj, alu_vk}, {tab[t].vj, tab[t].exp_vk});
            chk($sformatf("vec%0d_meta", t), {alu_rob, alu_pc, alu_op_type, alu_funct3, alu_funct7b},
                {tab[t].rob, 32'h100 + 32'(tab[t].rob) * 4, OP_ALU, tab[t].rob[2:0], tab[t].rob[0]});
            chk($sformatf("vec%0d_freed", t), count, 0);
            step();
            chk($sformatf("vec%0d_done", t), alu_valid, 0);
        end

        // wakeup two cycles after issue, on port 1
        put(4'd2, 32'd0, 32'h22, 1'b1, 4'd9, 1'b0, 4'd0);
        step(); idle(); step();
        chk("wake_wait", alu_valid, 0);
        cdb(1, 4'd9, 32'h1234); cdb(0, 4'd5, 32'h999);
        step(); idle();
        chk("wake_edge", alu_valid, 0);
        step();
        chk("wake_disp", {alu_valid, alu_rob, alu_vj, alu_vk}, {1'b1, 4'd2, 32'h1234, 32'h22});
        step();

        // age ordering across the tag wrap
        rob_head = 4'd14;
        put(4'd1, 32'd0, 32'd1, 1'b1, 4'd7, 1'b0, 4'd0); step();
        put(4'd15, 32'd0, 32'd2, 1'b1, 4'd7, 1'b0, 4'd0); step();
        idle(); cdb(0, 4'd7, 32'h77); step(); idle();
        chk("age_none", alu_valid, 0);
        step();
        chk("age_first", {alu_valid, alu_rob, alu_vj, alu_vk}, {1'b1, 4'd15, 32'h77, 32'd2});
        step();
        chk("age_second", {alu_valid, alu_rob, alu_vj, alu_vk}, {1'b1, 4'd1, 32'h77, 32'd1});
        step();
        chk("age_empty", alu_valid, 0);
        rob_head = 4'd0;

        // duplicate tag on both ports: port 0 wins
        put(4'd5, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd8); step();
        idle(); cdb(0, 4'd8, 32'hA0); cdb(1, 4'd8, 32'hB0); step(); idle(); step();
        chk("dup_port", {alu_valid, alu_vk}, {1'b1, 32'hA0});
        step();

        // fill under back-pressure, then drain one per cycle
        for (int k = 0; k < 10; k++) begin
            put(4'(k), 32'(k) * 16 + 1, 32'(k), 1'b0, 4'd0, 1'b0, 4'd0);
            alu_ready = 1'b0;
            step();
        end
        issue_valid = 1'b0;
        chk("fill_full", {full, count}, {1'b1, 4'd8});
        chk("fill_hold", {alu_valid, alu_rob, alu_vj}, {1'b1, 4'd0, 32'd1});
        step();
        chk("fill_stable", {alu_valid, alu_rob, alu_vj, count}, {1'b1, 4'd0, 32'd1, 4'd8});
        alu_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("drain%0d", k), {alu_valid, alu_rob, alu_vj, count, full},
                {1'b1, 4'(k), 32'(k) * 16 + 1, 4'(8 - k), 1'b0});
        end
        step();
        chk("drain_end", {alu_valid, count}, 0);

        // flush with five waiting entries and a held output
        for (int k = 0; k < 6; k++) begin
            put(4'(k), 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
            alu_ready = 1'b0;
            step();
        end
        issue_valid = 1'b0;
        chk("flush_pre", {alu_valid, count}, {1'b1, 4'd5});
        put(4'd10, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        flush_in = 1'b1; alu_ready = 1'b0;
        step(); idle();
        chk("flush_now", {alu_valid, count, full}, 0);
        step();
        chk("flush_after", {alu_valid, count}, 0);

        // rdy_in low: issue ignored, CDB data lost
        put(4'd4, 32'd1, 32'd2, 1'b1, 4'd3, 1'b0, 4'd0); step(); idle();
        chk("rdy_pend", count, 1);
        rdy_in = 1'b0; cdb(0, 4'd3, 32'h33);
        put(4'd5, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        step(); idle();
        chk("rdy_noissue", {alu_valid, count}, {1'b0, 4'd1});
        step();
        chk("rdy_cdb_lost", alu_valid, 0);
        cdb(0, 4'd3, 32'h44); step(); idle(); step();
        chk("rdy_wake", {alu_valid, alu_rob, alu_vj}, {1'b1, 4'd4, 32'h44});
        step();

        // frozen output, then reset mid-handshake with rdy_in low
        put(4'd7, 32'd7, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0); step();
        put(4'd11, 32'd11, 32'd11, 1'b0, 4'd0, 1'b0, 4'd0); step(); idle();
        chk("frz_pre", {alu_valid, alu_rob, count}, {1'b1, 4'd7, 4'd1});
        rdy_in = 1'b0;
        step();
        chk("frz_hold", {alu_valid, alu_rob, count}, {1'b1, 4'd7, 4'd1});
        rst_in = 1'b1;
        step();
        chk("rst_mid", {alu_valid, alu_vj, alu_vk, alu_pc, alu_rob, count, full}, 0);
        idle();
        put(4'd8, 32'h88, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        step(); idle();
        chk("rst_first_issue", count, 1);
        step();
        chk("rst_first_disp", {alu_valid, alu_rob, alu_vj}, {1'b1, 4'd8, 32'h88});
        step();

        for (int c = 0; c < 3000; c++) begin
            rst_in = (c == 0) || ($urandom_range(0, 199) == 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            flush_in = ($urandom_range(0, 59) == 0);
            rob_head = 4'($urandom);
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_rob = 4'($urandom); issue_pc = $urandom; issue_op_type = 7'($urandom);
            issue_funct3 = 3'($urandom); issue_funct7b = 1'($urandom);
            issue_vj = $urandom; issue_vk = $urandom;
            issue_qj_busy = ($urandom_range(0, 2) == 0); issue_qk_busy = ($urandom_range(0, 2) == 0);
            issue_qj = 4'($urandom); issue_qk = 4'($urandom);
            cdb_valid = 2'($urandom); cdb_rob = 8'($urandom); cdb_value = {$urandom, $urandom};
            alu_ready = ($urandom_range(0, 3) != 0);
            model_cycle();
            step();
            chk("rnd_status", {alu_valid, full, count}, {m_ov, m_count() == D, 4'(m_count())});
            if (m_ov)
                chk("rnd_payload", {alu_vj, alu_vk, alu_pc, alu_rob, alu_op_type, alu_funct3, alu_funct7b},
                    {o_vj, o_vk, o_pc, o_rob, o_ctl});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rs_station.md
RS_STATION -- requirements
Module: rs_station

Interface
REQ-001 Parameter RS_DEPTH, default 8: entry count, power of two, 2..32.
REQ-002 Parameter ROB_BITS, default 4: ROB tag width.
REQ-003 Parameter CDB_PORTS, default 2: number of result broadcast channels.
REQ-004 clk_in  in  1  sole clock; all logic on rising edge.
REQ-005 rst_in  in  1  synchronous, active-high reset.
REQ-006 rdy_in  in  1  low freezes all state and outputs.
REQ-007 flush_in  in  1  misprediction clear-up from ROB.
REQ-008 rob_head  in  ROB_BITS  oldest in-flight ROB tag, used for age ordering.
REQ-009 issue_valid  in  1  decoder issue request.
REQ-010 issue_op_type  in  7  opcode[6:0]; issue_funct3 in 3; issue_funct7b in 1 (inst[30]).
REQ-011 issue_vj, issue_vk  in  32 each  operand values.
REQ-012 issue_qj_busy, issue_qk_busy  in  1 each  operand pending.
REQ-013 issue_qj, issue_qk  in  ROB_BITS each  producer tags.
REQ-014 issue_rob  in  ROB_BITS  destination ROB tag; issue_pc in 32.
REQ-015 cdb_valid  in  CDB_PORTS; cdb_rob in CDB_PORTS*ROB_BITS; cdb_value in CDB_PORTS*32; port p occupies slice p.
REQ-016 alu_valid  out 1; alu_ready in 1; alu_vj, alu_vk, alu_pc out 32; alu_op_type out 7; alu_funct3 out 3; alu_funct7b out 1; alu_rob out ROB_BITS.
REQ-017 full  out  1  no free entry; count out $clog2(RS_DEPTH)+1 valid entries.

Function
REQ-018 Issue accepted at an edge iff issue_valid && !full; it writes the lowest-index free entry; issue while full is dropped, and the decoder stalls on full.
REQ-019 full and count reflect registered state only; an entry freed by dispatch in the same cycle is not visible to issue until the next cycle.
REQ-020 Wakeup: for every busy entry and every port p with cdb_valid[p], a pending operand whose tag equals cdb_rob[p] captures cdb_value[p] and clears its busy flag.
REQ-021 Issue bypass: an issuing operand with q_busy whose tag matches a valid CDB port in the same cycle is stored as ready with that CDB value.
REQ-022 Duplicate tags on several CDB ports in one cycle: the lowest port index wins.
REQ-023 Entry ready = busy && both operands not pending, evaluated on registered state; an entry woken at edge E is selectable in the cycle after E.
REQ-024 Selection is oldest-first: minimum (rob - rob_head) mod 2^ROB_BITS among ready entries, ties to the lowest index.
REQ-025 Output stage is a single register with valid/ready handshake; a new selection loads when !alu_valid || alu_ready, and the selected entry is freed at that same edge.
REQ-026 While alu_valid && !alu_ready, all alu_* outputs hold stable.
REQ-027 Latency: issue with ready operands accepted at edge E gives alu_valid high after edge E+1, if the output stage is free and no older entry is ready.
REQ-028 Sustained throughput is one dispatch per cycle when alu_ready is held high.
REQ-029 flush_in (with rdy_in high) clears all busy flags and alu_valid at that edge, overriding issue, wakeup and dispatch.
REQ-030 rdy_in low: no issue, wakeup, dispatch or flush takes effect; CDB data in that cycle is lost by contract.

Reset
REQ-031 rst_in high at an edge, regardless of rdy_in: all entries not busy, alu_valid=0, all alu_* data=0, full=0, count=0.
REQ-032 Reset mid-handshake drops the held output without completion; the first issue after reset is accepted in the cycle rst_in falls.

Structure
REQ-033 The shared constants header holds RS_DEPTH, ROB_BITS and CDB_PORTS defaults, plus opcode localparams for branch/ALU/JALR classes.
REQ-034 One sub-module, rs_age_select: combinational oldest-ready picker (ready mask, tags, rob_head in; index and found out).

Verification
REQ-035 Issue rob=3, vj=5, vk=7, no deps; alu_ready=1 -> alu_valid after edge E+1 with alu_vj=5, alu_vk=7, alu_rob=3; count returns to 0.
REQ-036 Issue rob=2 with qj=9 pending; cdb port1 broadcasts rob 9, value 0x1234 two cycles later -> dispatch with alu_vj=0x1234 one cycle after the broadcast edge.
REQ-037 rob_head=14; ready entries at rob 1 and rob 15 -> rob 15 dispatches first, then rob 1.
REQ-038 Fill 8 entries, hold alu_ready=0 -> full=1, 9th issue dropped, alu_* stable; release alu_ready -> one dispatch per cycle, full drops one cycle after the first dispatch.
REQ-039 Issue with qk=4 while cdb port0 broadcasts rob 4, value 0xAA in the same cycle -> entry ready, alu_vk=0xAA, no deadlock.
REQ-040 Flush with 5 busy entries and alu_valid=1 -> next cycle count=0 and alu_valid=0; issue asserted with flush is discarded.
